psum_requant_pp: RTL
====================

Name: psum_requant_pp

Overview:
- Parametrised post-processor between pe_engine and buffer_manager.
- Accumulates Tout-lane partial sums per output pixel/channel-tile across input-channel tiles in an on-chip psum RAM.
- On the last input-channel tile, applies per-channel bias, scale, rounding shift, activation and int8 saturation.
- Emits one packed OFM word with its buffer address.

Parameters:
- W_SIZE, 9, row/col/width bitwidth
- W_CHANNEL, 9, channel-tile index bitwidth
- Tout, 4, output lanes per PE word
- PSUM_DW, 32, signed psum lane width
- BIAS_DW, 16, signed bias width
- SCALES_DW, 16, unsigned scale width
- W_OUT, 8, signed output lane width
- OFM_DW, 32, output word width; must equal Tout*W_OUT
- OFM_AW, 16, OFM address width
- PSUM_AW, 14, psum RAM address width; depth 2**PSUM_AW words of Tout*PSUM_DW bits
- PRM_AW, 6, bias/scale table address width (channel-out tiles)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- q_start  in  1  layer start pulse; clears o_sat and o_out_cnt
- q_width  in  W_SIZE  layer width
- q_channel_out  in  W_CHANNEL  output channel tiles
- q_shift  in  5  requant right shift
- q_act  in  2  0 linear, 1 ReLU, 2 leaky (macro), 3 reserved = linear
- prm_we  in  1  bias/scale table write
- prm_addr  in  PRM_AW  channel-out tile
- prm_bias  in  Tout*BIAS_DW  packed biases
- prm_scale  in  Tout*SCALES_DW  packed scales
- pe_data_i  in  Tout*PSUM_DW  packed psums; lane g at [(g+1)*PSUM_DW-1 -: PSUM_DW]
- pe_vld_i  in  1  psum valid
- pe_row_i, pe_col_i  in  W_SIZE  pixel position
- pe_chn_i  in  W_CHANNEL  input-channel tile
- pe_chn_out_i  in  W_CHANNEL  output-channel tile
- pe_is_last_chn  in  1  last input tile for this entry
- o_pp_data_vld  out  1  output valid pulse
- o_pp_data  out  OFM_DW  packed int8 lanes; same lane layout as input
- o_pp_addr  out  OFM_AW  OFM word address
- o_sat  out  1  sticky: any lane clipped since q_start
- o_out_cnt  out  16  words emitted since q_start

Behaviour:
- Reset: all outputs 0, pipeline valids 0, tables 0. Psum RAM contents are not reset.
- Index idx = (pe_row_i*q_width + pe_col_i)*q_channel_out + pe_chn_out_i. idx is truncated to PSUM_AW for the RAM and to OFM_AW for o_pp_addr.
- No backpressure. One input per cycle is accepted every cycle.
- Fixed 4-stage pipeline. An input at edge T produces an output at edge T+3 when last.
  - S0: register inputs, compute idx, issue synchronous RAM read.
  - S1: acc = (pe_chn_i==0) ? pe_data : ram + pe_data, per lane, signed, wrapping at PSUM_DW. Write acc back to RAM at idx.
  - S2 (last only): v = (acc + sext(bias[g])) * zext(scale[g]), signed, full width with no overflow. Bias and scale come from the table at pe_chn_out_i.
  - S3: r = (v + (q_shift ? 1<<(q_shift-1) : 0)) >>> q_shift. Apply activation. Clip to [-128,127]. Assert o_pp_data_vld for 1 cycle.
- First-tile overwrite: pe_chn_i==0 ignores RAM content, so no clearing pass is needed.
- Hazard: if the S0 idx equals an idx being written in S1 or S2 (back-to-back or one gap), the accumulate uses the forwarded value, never stale RAM data. The youngest write wins.
- Single-tile layers: pe_chn_i==0 with pe_is_last_chn==1 outputs pe_data directly through requant.
- prm_we concurrent with a requant read of the same address: the read returns the old value. The new value applies from the next cycle.
- o_sat is set when any lane clips, and stays set until q_start or reset. o_out_cnt increments per output and wraps at 16 bits.
- If q_start and an output occur in the same cycle, the clear wins; that output is not counted.
- rstn assertion mid-operation drops all in-flight entries. No output is produced for them.

Optional Feature:
- Macro PP_LEAKY_RELU_EN.
- Defined: q_act==2 maps negative r to r>>>3 (slope 0.125), computed before clip.
- Undefined: q_act==2 behaves as linear, and no leaky logic is synthesised.

Test Plan:
- Tout=4, q_width=2, q_channel_out=1, bias 0, scale 1, shift 0, ReLU.
  - Stimulus: pixel (0,1) chn0 {10,20,-5,0}, then chn1 last {5,5,5,5} consecutive cycles.
  - Required: single output 3 cycles after last, lanes {15,25,0,5}, addr 1. Forwarding is exercised.
- Requant with bias 2, scale 3, shift 2, linear, single tile.
  - Stimulus: acc {10,-10,0,1}.
  - Required: {9,-6,2,2}, i.e. (36+2)>>2=9, (-24+2)>>2=-6, (6+2)>>2=2, (9+2)>>2=2.
- Saturation: acc {1000,-1000,127,-128}, scale 1, shift 0, linear.
  - Required: {127,-128,127,-128}, o_sat=1. A following q_start clears o_sat and o_out_cnt.
- Rounding: shift 1, acc {3,-3,1,-1}.
  - Required: {2,-1,1,0}.
- Leaky, with PP_LEAKY_RELU_EN: acc {-80,80,-7,0}, q_act=2.
  - Required: {-10,80,-1,0}.
  - Without the macro: {-80,80,-7,0}.
- Reset mid-stream: pulse rstn low 1 cycle after a last-tile input.
  - Required: no o_pp_data_vld and all outputs 0 afterwards. The next chn0/last sequence produces a correct result.

Source files
------------

// File: rtl/psum_requant_pp.sv
// psum_requant_pp: accumulates Tout-lane partial sums per output pixel and
// channel-out tile across input-channel tiles in an on-chip psum RAM. On the
// last input tile it applies bias, scale, rounding shift, activation and int8
// saturation. It then emits one packed OFM word together with its address.
// Optional build macro: PP_LEAKY_RELU_EN enables the leaky ReLU (q_act==2,
// slope 1/8). When the macro is undefined, q_act==2 behaves as linear.
module psum_requant_pp #(
    parameter int W_SIZE    = 9,
    parameter int W_CHANNEL = 9,
    parameter int Tout      = 4,
    parameter int PSUM_DW   = 32,
    parameter int BIAS_DW   = 16,
    parameter int SCALES_DW = 16,
    parameter int W_OUT     = 8,
    parameter int OFM_DW    = 32,
    parameter int OFM_AW    = 16,
    parameter int PSUM_AW   = 14,
    parameter int PRM_AW    = 6
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      q_start,
    input  logic [W_SIZE-1:0]         q_width,
    input  logic [W_CHANNEL-1:0]      q_channel_out,
    input  logic [4:0]                q_shift,
    input  logic [1:0]                q_act,
    input  logic                      prm_we,
    input  logic [PRM_AW-1:0]         prm_addr,
    input  logic [Tout*BIAS_DW-1:0]   prm_bias,
    input  logic [Tout*SCALES_DW-1:0] prm_scale,
    input  logic [Tout*PSUM_DW-1:0]   pe_data_i,
    input  logic                      pe_vld_i,
    input  logic [W_SIZE-1:0]         pe_row_i,
    input  logic [W_SIZE-1:0]         pe_col_i,
    input  logic [W_CHANNEL-1:0]      pe_chn_i,
    input  logic [W_CHANNEL-1:0]      pe_chn_out_i,
    input  logic                      pe_is_last_chn,
    output logic                      o_pp_data_vld,
    output logic [OFM_DW-1:0]         o_pp_data,
    output logic [OFM_AW-1:0]         o_pp_addr,
    output logic                      o_sat,
    output logic [15:0]               o_out_cnt
);

    localparam int LANES_W    = Tout * PSUM_DW;
    localparam int IDX_W      = (OFM_AW > PSUM_AW) ? OFM_AW : PSUM_AW;
    localparam int V_W        = PSUM_DW + SCALES_DW + 2;  // exact product width
    localparam int R_W        = V_W + 1;                  // headroom for rounding add
    localparam int PSUM_DEPTH = 1 << PSUM_AW;
    localparam int PRM_DEPTH  = 1 << PRM_AW;

    // Linear index; only the low IDX_W bits are ever needed, and modular
    // arithmetic keeps those exact.
    logic [IDX_W-1:0] idx_full;
    assign idx_full = (IDX_W'(pe_row_i) * IDX_W'(q_width) + IDX_W'(pe_col_i))
                      * IDX_W'(q_channel_out) + IDX_W'(pe_chn_out_i);

    // Pipeline state
    logic                  s0_vld_q, s1_vld_q, s2_vld_q;
    logic [LANES_W-1:0]    s0_data_q, s1_data_q;
    logic [PSUM_AW-1:0]    s0_pidx_q, s1_pidx_q, s2_pidx_q;
    logic [OFM_AW-1:0]     s0_oaddr_q, s1_oaddr_q, s2_oaddr_q;
    logic                  s0_first_q, s1_first_q;
    logic                  s0_last_q, s1_last_q, s2_last_q;
    logic [PRM_AW-1:0]     s0_tile_q, s1_tile_q;
    logic [LANES_W-1:0]    s2_acc_q;
    logic [Tout*V_W-1:0]   s2_v_q;

    logic [LANES_W-1:0]    ram_rd_q;
    logic [LANES_W-1:0]    psum_ram [PSUM_DEPTH];

    logic [Tout*BIAS_DW-1:0]   bias_tab_q  [PRM_DEPTH];
    logic [Tout*SCALES_DW-1:0] scale_tab_q [PRM_DEPTH];

    logic [LANES_W-1:0]        acc_d;
    logic [LANES_W-1:0]        old_psum;
    logic                      fwd_hit;
    logic [Tout*V_W-1:0]       v_d;
    logic [Tout*BIAS_DW-1:0]   bias_row;
    logic [Tout*SCALES_DW-1:0] scale_row;
    logic [OFM_DW-1:0]         out_d;
    logic [Tout-1:0]           clip_hi, clip_lo;
    logic                      out_fire;

    logic                      vld_q, sat_q;
    logic [OFM_DW-1:0]         data_q;
    logic [OFM_AW-1:0]         addr_q;
    logic [15:0]               cnt_q;

    // Stage valids; reset drops every in-flight entry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s0_vld_q <= 1'b0;
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
        end else begin
            s0_vld_q <= pe_vld_i;
            s1_vld_q <= s0_vld_q;
            s2_vld_q <= s1_vld_q;
        end
    end

    // Stage payloads; they are only meaningful when qualified by the valids.
    always_ff @(posedge clk) begin
        s0_data_q  <= pe_data_i;
        s0_pidx_q  <= idx_full[PSUM_AW-1:0];
        s0_oaddr_q <= idx_full[OFM_AW-1:0];
        s0_first_q <= (pe_chn_i == '0);
        s0_last_q  <= pe_is_last_chn;
        s0_tile_q  <= pe_chn_out_i[PRM_AW-1:0];

        s1_data_q  <= s0_data_q;
        s1_pidx_q  <= s0_pidx_q;
        s1_oaddr_q <= s0_oaddr_q;
        s1_first_q <= s0_first_q;
        s1_last_q  <= s0_last_q;
        s1_tile_q  <= s0_tile_q;

        s2_pidx_q  <= s1_pidx_q;
        s2_oaddr_q <= s1_oaddr_q;
        s2_last_q  <= s1_last_q;
        s2_acc_q   <= acc_d;
        s2_v_q     <= v_d;
    end

    // Psum RAM: registered read for the S0 entry, write-back of the S1 accumulation.
    always_ff @(posedge clk) begin
        if (s1_vld_q) begin
            psum_ram[s1_pidx_q] <= acc_d;
        end
        ram_rd_q <= psum_ram[s0_pidx_q];
    end

    // Bias/scale tables. A write lands at the clock edge, so a requant
    // in the same cycle still sees the old entry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < PRM_DEPTH; i++) begin
                bias_tab_q[i]  <= '0;
                scale_tab_q[i] <= '0;
            end
        end else if (prm_we) begin
            bias_tab_q[prm_addr]  <= prm_bias;
            scale_tab_q[prm_addr] <= prm_scale;
        end
    end

    // The only write the registered read can miss is the one from the entry
    // directly ahead: it lands on the same edge as the read. Take that
    // value from S2 instead.
    assign fwd_hit   = s2_vld_q && (s2_pidx_q == s1_pidx_q);
    assign old_psum  = fwd_hit ? s2_acc_q : ram_rd_q;
    assign bias_row  = bias_tab_q[s1_tile_q];
    assign scale_row = scale_tab_q[s1_tile_q];
    assign out_fire  = s2_vld_q && s2_last_q;

    genvar gi;
    generate
        for (gi = 0; gi < Tout; gi++) begin : g_lane
            logic signed [PSUM_DW-1:0] pe_lane, old_lane, acc_lane;
            logic [BIAS_DW-1:0]        bias_lane;
            logic [SCALES_DW-1:0]      scale_lane;
            logic signed [V_W-1:0]     biased_x, scale_x;
            logic signed [R_W-1:0]     v_x, rnd, sum, r, act;

            assign pe_lane  = s1_data_q[(gi+1)*PSUM_DW-1 -: PSUM_DW];
            assign old_lane = old_psum[(gi+1)*PSUM_DW-1 -: PSUM_DW];
            // First input tile overwrites, so stale RAM never needs clearing.
            assign acc_lane = s1_first_q ? pe_lane : pe_lane + old_lane;
            assign acc_d[(gi+1)*PSUM_DW-1 -: PSUM_DW] = acc_lane;

            assign bias_lane  = bias_row[(gi+1)*BIAS_DW-1 -: BIAS_DW];
            assign scale_lane = scale_row[(gi+1)*SCALES_DW-1 -: SCALES_DW];
            assign biased_x   = {{(V_W-PSUM_DW){acc_lane[PSUM_DW-1]}}, acc_lane}
                              + {{(V_W-BIAS_DW){bias_lane[BIAS_DW-1]}}, bias_lane};
            assign scale_x    = {{(V_W-SCALES_DW){1'b0}}, scale_lane};
            assign v_d[(gi+1)*V_W-1 -: V_W] = biased_x * scale_x;

            // Round half up, then arithmetic shift.
            assign v_x = {s2_v_q[(gi+1)*V_W-1], s2_v_q[(gi+1)*V_W-1 -: V_W]};
            assign rnd = (R_W'(1) << q_shift) >> 1;
            assign sum = v_x + rnd;
            assign r   = sum >>> q_shift;

            // Activation on the rounded value, before clipping.
            always_comb begin
                act = r;
                if (q_act == 2'd1 && r[R_W-1]) begin
                    act = '0;
                end
`ifdef PP_LEAKY_RELU_EN
                else if (q_act == 2'd2 && r[R_W-1]) begin
                    act = r >>> 3;
                end
`endif
            end

            assign clip_hi[gi] = !act[R_W-1] && (|act[R_W-2:W_OUT-1]);
            assign clip_lo[gi] = act[R_W-1] && !(&act[R_W-2:W_OUT-1]);
            assign out_d[(gi+1)*W_OUT-1 -: W_OUT] =
                clip_hi[gi] ? {1'b0, {(W_OUT-1){1'b1}}} :
                clip_lo[gi] ? {1'b1, {(W_OUT-1){1'b0}}} :
                              act[W_OUT-1:0];
        end
    endgenerate

    // Output word, sticky saturation flag and output counter. When q_start
    // and an output arrive together, the clear wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            addr_q <= '0;
            sat_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            vld_q <= out_fire;
            if (out_fire) begin
                data_q <= out_d;
                addr_q <= s2_oaddr_q;
            end
            if (q_start) begin
                sat_q <= 1'b0;
                cnt_q <= '0;
            end else if (out_fire) begin
                sat_q <= sat_q | (|(clip_hi | clip_lo));
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign o_pp_data_vld = vld_q;
    assign o_pp_data     = data_q;
    assign o_pp_addr     = addr_q;
    assign o_sat         = sat_q;
    assign o_out_cnt     = cnt_q;

endmodule
